xhci_event_ring_engine: RTL and testbench

//  Multi-requester, multi-interrupter xHCI Event Ring enqueue engine; successor of the single-channel writer plus fixed 3-way mux.

---
 rtl/xhci_event_ring_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_xhci_event_ring_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xhci_event_ring_engine.sv
// rtl/xhci_event_ring_engine.sv - multi-requester xHCI Event Ring enqueue engine
//
// Purpose: round-robin arbitrates NUM_REQ event sources, caches per-interrupter
// ERST segment state, and writes 16-byte Event TRBs to host memory. Each write
// is followed by an MSI-X request unless the event carries BEI. The engine also
// detects a full Event Ring.
//
// Ports:
//   i_clk_pcie, i_rst                       clock, async active-high reset
//   i_req_valid/intr/trb/bei                per-requester event (held until done)
//   o_req_done, o_req_full                  completion pulse, ring-full flag
//   i_rt_erstba/erstsz/erdp                 per-interrupter runtime registers
//   i_intr_enable                           IMAN.IE set pulse, invalidates cache
//   o_mwr_*/i_mwr_done                      16-byte memory write
//   o_mrd_*/i_mrd_done/i_mrd_data           16-byte ERST entry read
//   o_msix_*/i_msix_done                    MSI-X fire request
//   o_evt_int_set                           IMAN.IP set pulse per interrupter
module xhci_event_ring_engine #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_INTR = 8,
    parameter int IW       = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
    input  logic                    i_clk_pcie,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*IW-1:0]   i_req_intr,
    input  logic [NUM_REQ*128-1:0]  i_req_trb,
    input  logic [NUM_REQ-1:0]      i_req_bei,
    output logic [NUM_REQ-1:0]      o_req_done,
    output logic                    o_req_full,
    input  logic [NUM_INTR*58-1:0]  i_rt_erstba,
    input  logic [NUM_INTR*16-1:0]  i_rt_erstsz,
    input  logic [NUM_INTR*60-1:0]  i_rt_erdp,
    input  logic [NUM_INTR-1:0]     i_intr_enable,
    output logic                    o_mwr_valid,
    output logic [63:0]             o_mwr_addr,
    output logic [127:0]            o_mwr_data,
    input  logic                    i_mwr_done,
    output logic                    o_mrd_valid,
    output logic [63:0]             o_mrd_addr,
    input  logic                    i_mrd_done,
    input  logic [127:0]            i_mrd_data,
    output logic                    o_msix_valid,
    output logic [IW-1:0]           o_msix_vector,
    input  logic                    i_msix_done,
    output logic [NUM_INTR-1:0]     o_evt_int_set
);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_CHECK, S_WRITE,
        S_WRITE_WAIT, S_MSIX, S_MSIX_WAIT, S_DONE
    } state_t;

    state_t         r_state;
    logic [RW-1:0]  r_rr;
    logic [RW-1:0]  r_req;
    logic [IW-1:0]  r_intr;
    logic [127:0]   r_trb;
    logic           r_bei;

    // Per-interrupter segment cache
    logic           r_c_valid [NUM_INTR];
    logic [59:0]    r_c_enq   [NUM_INTR];
    logic [15:0]    r_c_seg   [NUM_INTR];
    logic [15:0]    r_c_rem   [NUM_INTR];
    logic           r_c_ccs   [NUM_INTR];
    logic [NUM_INTR-1:0] r_clr_pend;

    logic           w_gnt_any;
    logic [RW-1:0]  w_gnt;
    logic [RW-1:0]  w_rr_next;
    logic [IW-1:0]  w_gnt_intr;
    logic [57:0]    w_erstba;
    logic [15:0]    w_erstsz;
    logic [15:0]    w_sz_eff;
    logic [59:0]    w_erdp;
    logic [59:0]    w_cur_enq;
    logic [15:0]    w_cur_rem;
    logic [15:0]    w_cur_seg;
    logic           w_cur_ccs;
    logic           w_busy;
    logic [NUM_INTR-1:0] w_clr;
    logic           w_unused;

    // Round-robin: first requester at or after r_rr, wrapping
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_any && i_req_valid[(int'(r_rr) + k) % NUM_REQ]) begin
                w_gnt_any = 1'b1;
                w_gnt     = RW'((int'(r_rr) + k) % NUM_REQ);
            end
        end
    end

    assign w_rr_next  = (w_gnt == RW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
    assign w_gnt_intr = i_req_intr[int'(w_gnt)*IW +: IW];

    assign w_erstba  = i_rt_erstba[int'(r_intr)*58 +: 58];
    assign w_erstsz  = i_rt_erstsz[int'(r_intr)*16 +: 16];
    assign w_erdp    = i_rt_erdp[int'(r_intr)*60 +: 60];
    assign w_sz_eff  = (w_erstsz == 16'd0) ? 16'd1 : w_erstsz;
    assign w_cur_enq = r_c_enq[r_intr];
    assign w_cur_rem = r_c_rem[r_intr];
    assign w_cur_seg = r_c_seg[r_intr];
    assign w_cur_ccs = r_c_ccs[r_intr];

    // An interrupter is in flight from grant until the DONE state; an IE
    // pulse for it is parked and applied once the event has completed.
    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_clr  = r_clr_pend | i_intr_enable;

    assign w_unused = ^{i_mrd_data[127:80], i_mrd_data[5:0], r_trb[96]};

    always_ff @(posedge i_clk_pcie or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_req         <= '0;
            r_intr        <= '0;
            r_trb         <= '0;
            r_bei         <= 1'b0;
            r_clr_pend    <= '0;
            o_req_done    <= '0;
            o_req_full    <= 1'b0;
            o_mwr_valid   <= 1'b0;
            o_mwr_addr    <= '0;
            o_mwr_data    <= '0;
            o_mrd_valid   <= 1'b0;
            o_mrd_addr    <= '0;
            o_msix_valid  <= 1'b0;
            o_msix_vector <= '0;
            o_evt_int_set <= '0;
            for (int k = 0; k < NUM_INTR; k++) begin
                r_c_valid[k] <= 1'b0;
                r_c_enq[k]   <= '0;
                r_c_seg[k]   <= '0;
                r_c_rem[k]   <= '0;
                r_c_ccs[k]   <= 1'b1;
            end
        end else begin
            o_req_done    <= '0;
            o_req_full    <= 1'b0;
            o_evt_int_set <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_req   <= w_gnt;
                        r_intr  <= w_gnt_intr;
                        r_trb   <= i_req_trb[int'(w_gnt)*128 +: 128];
                        r_bei   <= i_req_bei[w_gnt];
                        r_rr    <= w_rr_next;
                        // A same-cycle or parked clear invalidates the entry now
                        r_state <= (r_c_valid[w_gnt_intr] && !w_clr[w_gnt_intr])
                                   ? S_CHECK : S_FETCH;
                    end
                end
                S_FETCH: begin
                    o_mrd_valid <= 1'b1;
                    o_mrd_addr  <= {w_erstba, 6'h0} + {44'h0, w_cur_seg, 4'h0};
                    r_state     <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (i_mrd_done) begin
                        o_mrd_valid       <= 1'b0;
                        r_c_enq[r_intr]   <= {i_mrd_data[63:6], 2'b00};
                        r_c_rem[r_intr]   <= i_mrd_data[79:64];
                        r_c_valid[r_intr] <= 1'b1;
                        r_state           <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // No lookahead across a segment boundary on the last slot
                    if (w_cur_rem > 16'd1 && (w_cur_enq + 60'd1) == w_erdp) begin
                        o_req_done[r_req] <= 1'b1;
                        o_req_full        <= 1'b1;
                        r_state           <= S_DONE;
                    end else begin
                        o_evt_int_set[r_intr] <= 1'b1;
                        r_state               <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    o_mwr_valid <= 1'b1;
                    o_mwr_addr  <= {w_cur_enq, 4'h0};
                    o_mwr_data  <= {r_trb[127:97], w_cur_ccs, r_trb[95:0]};
                    r_state     <= S_WRITE_WAIT;
                end
                S_WRITE_WAIT: begin
                    if (i_mwr_done) begin
                        o_mwr_valid     <= 1'b0;
                        r_c_enq[r_intr] <= w_cur_enq + 60'd1;
                        r_c_rem[r_intr] <= w_cur_rem - 16'd1;
                        if (w_cur_rem == 16'd1) begin
                            r_c_valid[r_intr] <= 1'b0;
                            if (({1'b0, w_cur_seg} + 17'd1) >= {1'b0, w_sz_eff}) begin
                                r_c_seg[r_intr] <= '0;
                                r_c_ccs[r_intr] <= ~w_cur_ccs;
                            end else begin
                                r_c_seg[r_intr] <= w_cur_seg + 16'd1;
                            end
                        end
                        if (r_bei) begin
                            o_req_done[r_req] <= 1'b1;
                            r_state           <= S_DONE;
                        end else begin
                            r_state <= S_MSIX;
                        end
                    end
                end
                S_MSIX: begin
                    o_msix_valid  <= 1'b1;
                    o_msix_vector <= r_intr;
                    r_state       <= S_MSIX_WAIT;
                end
                S_MSIX_WAIT: begin
                    if (i_msix_done) begin
                        o_msix_valid      <= 1'b0;
                        o_req_done[r_req] <= 1'b1;
                        r_state           <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Placed last so a clear overrides any cache update of the same cycle
            for (int k = 0; k < NUM_INTR; k++) begin
                if (w_clr[k]) begin
                    if (w_busy && r_intr == IW'(k)) begin
                        r_clr_pend[k] <= 1'b1;
                    end else begin
                        r_c_valid[k]  <= 1'b0;
                        r_c_seg[k]    <= '0;
                        r_c_ccs[k]    <= 1'b1;
                        r_clr_pend[k] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_xhci_event_ring_engine.sv
// tb/tb_xhci_event_ring_engine.sv - scoreboard bench for xhci_event_ring_engine
module tb_xhci_event_ring_engine;
    localparam int NR = 3;
    localparam int NI = 8;
    localparam int IW = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       i_req_valid = '0;
    logic [NR*IW-1:0]    i_req_intr = '0;
    logic [NR*128-1:0]   i_req_trb = '0;
    logic [NR-1:0]       i_req_bei = '0;
    logic [NR-1:0]       o_req_done;
    logic                o_req_full;
    logic [NI*58-1:0]    i_rt_erstba = '0;
    logic [NI*16-1:0]    i_rt_erstsz = '0;
    logic [NI*60-1:0]    i_rt_erdp = '0;
    logic [NI-1:0]       i_intr_enable = '0;
    logic                o_mwr_valid;
    logic [63:0]         o_mwr_addr;
    logic [127:0]        o_mwr_data;
    logic                i_mwr_done = 1'b0;
    logic                o_mrd_valid;
    logic [63:0]         o_mrd_addr;
    logic                i_mrd_done = 1'b0;
    logic [127:0]        i_mrd_data = '0;
    logic                o_msix_valid;
    logic [IW-1:0]       o_msix_vector;
    logic                i_msix_done = 1'b0;
    logic [NI-1:0]       o_evt_int_set;

    xhci_event_ring_engine #(.NUM_REQ(NR), .NUM_INTR(NI)) dut (
        .i_clk_pcie(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .i_req_intr(i_req_intr), .i_req_trb(i_req_trb),
        .i_req_bei(i_req_bei), .o_req_done(o_req_done), .o_req_full(o_req_full),
        .i_rt_erstba(i_rt_erstba), .i_rt_erstsz(i_rt_erstsz), .i_rt_erdp(i_rt_erdp),
        .i_intr_enable(i_intr_enable),
        .o_mwr_valid(o_mwr_valid), .o_mwr_addr(o_mwr_addr), .o_mwr_data(o_mwr_data),
        .i_mwr_done(i_mwr_done),
        .o_mrd_valid(o_mrd_valid), .o_mrd_addr(o_mrd_addr), .i_mrd_done(i_mrd_done),
        .i_mrd_data(i_mrd_data),
        .o_msix_valid(o_msix_valid), .o_msix_vector(o_msix_vector), .i_msix_done(i_msix_done),
        .o_evt_int_set(o_evt_int_set)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_n    = 0;
    bit hold_mwr = 1'b0;

    logic [63:0]  exp_mrd_q[$];
    logic [63:0]  exp_mwr_a_q[$];
    logic [127:0] exp_mwr_d_q[$];
    int           exp_msix_q[$];
    int           exp_int_q[$];
    int           exp_done_q[$];
    logic [127:0] erst_mem [logic [63:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [127:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected activity, value %0h", name, act);
    endtask

    // Responders and scoreboard monitor
    always @(negedge clk) begin
        int e;
        if (rst) begin
            i_mrd_done  = 1'b0;
            i_mwr_done  = 1'b0;
            i_msix_done = 1'b0;
        end else begin
            if (i_mrd_done) i_mrd_done = 1'b0;
            else if (o_mrd_valid) begin
                if (exp_mrd_q.size() == 0) bad("mrd_addr", o_mrd_addr);
                else chk("mrd_addr", o_mrd_addr, exp_mrd_q.pop_front());
                i_mrd_data = erst_mem.exists(o_mrd_addr) ? erst_mem[o_mrd_addr] : '0;
                i_mrd_done = 1'b1;
            end
            if (i_mwr_done) i_mwr_done = 1'b0;
            else if (o_mwr_valid && !hold_mwr) begin
                if (exp_mwr_a_q.size() == 0) bad("mwr_addr", o_mwr_addr);
                else begin
                    chk("mwr_addr", o_mwr_addr, exp_mwr_a_q.pop_front());
                    chk("mwr_data", o_mwr_data, exp_mwr_d_q.pop_front());
                end
                i_mwr_done = 1'b1;
            end
            if (i_msix_done) i_msix_done = 1'b0;
            else if (o_msix_valid) begin
                if (exp_msix_q.size() == 0) bad("msix_vector", o_msix_vector);
                else chk("msix_vector", o_msix_vector, IW'(exp_msix_q.pop_front()));
                i_msix_done = 1'b1;
            end
            if (o_evt_int_set != '0) begin
                if (exp_int_q.size() == 0) bad("evt_int_set", o_evt_int_set);
                else chk("evt_int_set", o_evt_int_set, NI'(1) << exp_int_q.pop_front());
            end
            if (o_req_done != '0) begin
                if (exp_done_q.size() == 0) bad("req_done", o_req_done);
                else begin
                    e = exp_done_q.pop_front();
                    chk("req_done_full", {o_req_full, o_req_done},
                        {e[0], NR'(NR'(1) << (e / 2))});
                end
            end else if (o_req_full) bad("req_full_alone", o_req_full);
        end
    end

    task automatic cfg(input int k, input logic [63:0] erst, input logic [15:0] sz,
                       input logic [63:0] erdp);
        i_rt_erstba[k*58 +: 58] = erst[63:6];
        i_rt_erstsz[k*16 +: 16] = sz;
        i_rt_erdp[k*60 +: 60]   = erdp[63:4];
    endtask

    task automatic set_req(input int r, input int k, input logic [127:0] trb, input bit bei);
        i_req_intr[r*IW +: IW] = IW'(k);
        i_req_trb[r*128 +: 128] = trb;
        i_req_bei[r] = bei;
    endtask

    task automatic mk_trb(output logic [127:0] trb);
        ev_n++;
        trb = {32'hA000_0001 + 32'(ev_n * 3), 32'(ev_n), 32'hDEAD_BEEF, 32'hC0DE_0000 + 32'(ev_n)};
    endtask

    task automatic exp_evt(input int r, input int k, input logic [63:0] mrd,
                           input logic [63:0] wa, input logic [127:0] trb,
                           input bit cyc, input bit bei, input bit full);
        logic [127:0] d;
        if (mrd != 64'd0) exp_mrd_q.push_back(mrd);
        if (!full) begin
            d = trb;
            d[96] = cyc;
            exp_mwr_a_q.push_back(wa);
            exp_mwr_d_q.push_back(d);
            exp_int_q.push_back(k);
            if (!bei) exp_msix_q.push_back(k);
        end
        exp_done_q.push_back(r * 2 + int'(full));
    endtask

    task automatic run(input logic [NR-1:0] mask);
        logic [NR-1:0] pend;
        int cyc;
        pend = mask;
        cyc = 0;
        i_req_valid = i_req_valid | mask;
        while (pend != '0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if ((o_req_done & pend) != '0) begin
                i_req_valid = i_req_valid & ~o_req_done;
                pend = pend & ~o_req_done;
            end
        end
        if (pend != '0) begin
            bad("req_done_timeout", pend);
            i_req_valid = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int r, input int k, input bit bei, input logic [63:0] mrd,
                        input logic [63:0] wa, input bit cyc, input bit full);
        logic [127:0] trb;
        mk_trb(trb);
        set_req(r, k, trb, bei);
        exp_evt(r, k, mrd, wa, trb, cyc, bei, full);
        run(NR'(NR'(1) << r));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_done"}, o_req_done, 0);
        chk({tag, "_req_full"}, o_req_full, 0);
        chk({tag, "_mwr"}, {o_mwr_valid, o_mwr_addr}, 0);
        chk({tag, "_mwr_data"}, o_mwr_data, 0);
        chk({tag, "_mrd"}, {o_mrd_valid, o_mrd_addr}, 0);
        chk({tag, "_msix"}, {o_msix_valid, o_msix_vector}, 0);
        chk({tag, "_int_set"}, o_evt_int_set, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");
    endtask

    initial begin
        int cnt;
        logic [127:0] trb;
        // ERST tables: intr0 @0x8000, intr3 @0x9000, intr1 @0xA000, intr2 @0xB000
        erst_mem[64'h8000] = {48'h0, 16'd4, 64'h1000};
        erst_mem[64'h9000] = {48'h0, 16'd2, 64'h1000};
        erst_mem[64'h9010] = {48'h0, 16'd2, 64'h2000};
        erst_mem[64'hA000] = {48'h0, 16'd8, 64'h5000};
        erst_mem[64'hB000] = {48'h0, 16'd2, 64'h6000};
        cfg(0, 64'h8000, 16'd1, 64'h0);
        cfg(3, 64'h9000, 16'd2, 64'h0);
        cfg(1, 64'hA000, 16'd0, 64'h0);
        cfg(2, 64'hB000, 16'd1, 64'h0);
        do_reset();

        // Cold start, then fill the 4-entry ring and wrap with cycle toggle
        send(0, 0, 0, 64'h8000, 64'h1000, 1, 0);
        send(0, 0, 0, 64'h0,    64'h1010, 1, 0);
        send(0, 0, 1, 64'h0,    64'h1020, 1, 0);
        send(0, 0, 0, 64'h0,    64'h1030, 1, 0);
        send(0, 0, 0, 64'h8000, 64'h1000, 0, 0);

        // Two-segment ERST on intr3
        send(2, 3, 0, 64'h9000, 64'h1000, 1, 0);
        send(2, 3, 1, 64'h0,    64'h1010, 1, 0);
        send(2, 3, 0, 64'h9010, 64'h2000, 1, 0);
        send(2, 3, 1, 64'h0,    64'h2010, 1, 0);
        send(2, 3, 0, 64'h9000, 64'h1000, 0, 0);

        // Ring full on intr0, then freed; last slot of segment skips full check
        do_reset();
        cfg(0, 64'h8000, 16'd1, 64'h1030);
        send(0, 0, 0, 64'h8000, 64'h1000, 1, 0);
        send(0, 0, 0, 64'h0,    64'h1010, 1, 0);
        send(0, 0, 0, 64'h0,    64'h0,    1, 1);
        cfg(0, 64'h8000, 16'd1, 64'h0);
        send(0, 0, 0, 64'h0,    64'h1020, 1, 0);
        cfg(0, 64'h8000, 16'd1, 64'h1040);
        send(0, 0, 0, 64'h0,    64'h1030, 1, 0);

        // Round-robin among all three requesters, BEI on requester 1
        do_reset();
        mk_trb(trb); set_req(0, 1, trb, 0); exp_evt(0, 1, 64'hA000, 64'h5000, trb, 1, 0, 0);
        mk_trb(trb); set_req(1, 1, trb, 1); exp_evt(1, 1, 64'h0,    64'h5010, trb, 1, 1, 0);
        mk_trb(trb); set_req(2, 1, trb, 0); exp_evt(2, 1, 64'h0,    64'h5020, trb, 1, 0, 0);
        run(3'b111);

        // IE pulse resets cached cycle state on intr2
        send(0, 2, 0, 64'hB000, 64'h6000, 1, 0);
        send(0, 2, 0, 64'h0,    64'h6010, 1, 0);
        send(0, 2, 0, 64'hB000, 64'h6000, 0, 0);
        i_intr_enable[2] = 1'b1;
        @(negedge clk);
        i_intr_enable[2] = 1'b0;
        @(negedge clk);
        send(0, 2, 0, 64'hB000, 64'h6000, 1, 0);

        // Async reset while the write is outstanding
        hold_mwr = 1'b1;
        mk_trb(trb);
        set_req(0, 2, trb, 0);
        exp_int_q.push_back(2);
        i_req_valid[0] = 1'b1;
        cnt = 0;
        while (!o_mwr_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_mwr_valid", o_mwr_valid, 1);
        chk("held_mwr_addr", o_mwr_addr, 64'h6010);
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        i_req_valid = '0;
        hold_mwr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        chk("q_mrd_empty",  exp_mrd_q.size(), 0);
        chk("q_mwr_empty",  exp_mwr_a_q.size(), 0);
        chk("q_msix_empty", exp_msix_q.size(), 0);
        chk("q_int_empty",  exp_int_q.size(), 0);
        chk("q_done_empty", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
